// File: rtl/inst_mem_loader_if.sv
// Host beat stream into the instruction memory loader: data/valid from the host,
// ready back from the loader.
interface inst_mem_loader_if #(
    parameter int HOST_DWIDTH = 32
);
    logic [HOST_DWIDTH-1:0] Host_Data;
    logic                   Host_Valid;
    logic                   Host_Ready;

    modport master (output Host_Data, output Host_Valid, input Host_Ready);
    modport slave  (input Host_Data, input Host_Valid, output Host_Ready);
endinterface

// File: rtl/inst_mem_loader.sv
// Packs host beats into instruction words and writes them sequentially into the
// write port of the CGRA instruction RAM, stalling while the CGRA is running.
module inst_mem_loader #(
    parameter int INST_DWIDTH = 72,
    parameter int INST_AWIDTH = 10,
    parameter int HOST_DWIDTH = 32
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   Load_Start,
    input  logic [INST_AWIDTH-1:0] Load_Base,
    input  logic [INST_AWIDTH:0]   Load_Len,
    inst_mem_loader_if.slave       host,
    input  logic                   CGRA_Ena,
    output logic                   Inst_Wr_En,
    output logic [INST_AWIDTH-1:0] Inst_Wr_Addr,
    output logic [INST_DWIDTH-1:0] Inst_Wr_Data,
    output logic                   Load_Busy,
    output logic                   Load_Done
);
    localparam int BEATS = (INST_DWIDTH + HOST_DWIDTH - 1) / HOST_DWIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
    localparam logic [INST_AWIDTH:0] ONE_INST  = (INST_AWIDTH + 1)'(1);

    // FLUSH lets the final registered write go out before Done pulses.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [INST_AWIDTH-1:0] base_q, base_d;
    logic [INST_AWIDTH:0]   len_q, len_d;
    logic [INST_AWIDTH:0]   inst_cnt_q, inst_cnt_d;
    logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [INST_DWIDTH-1:0] pack_q, pack_d;
    logic                   wr_en_q, wr_en_d;
    logic [INST_AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [INST_DWIDTH-1:0] wr_data_q, wr_data_d;
    logic                   beat_fire;

    assign host.Host_Ready = (state_q == S_LOAD) && !CGRA_Ena;
    assign beat_fire       = host.Host_Valid && host.Host_Ready;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        inst_cnt_d = inst_cnt_q;
        beat_cnt_d = beat_cnt_q;
        pack_d     = pack_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (Load_Start) begin
                    base_d     = Load_Base;
                    len_d      = Load_Len;
                    inst_cnt_d = '0;
                    beat_cnt_d = '0;
                    pack_d     = '0;
                    state_d    = (Load_Len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat_fire) begin
                    // Beat k fills word bits [k*HOST_DWIDTH +: HOST_DWIDTH]; bits past the word are dropped.
                    for (int i = 0; i < INST_DWIDTH; i++) begin
                        if ((i / HOST_DWIDTH) == int'(beat_cnt_q)) begin
                            pack_d[i] = host.Host_Data[i % HOST_DWIDTH];
                        end
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = base_q + inst_cnt_q[INST_AWIDTH-1:0];
                        wr_data_d  = pack_d;
                        beat_cnt_d = '0;
                        inst_cnt_d = inst_cnt_q + ONE_INST;
                        if (inst_cnt_d == len_q) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            inst_cnt_q <= '0;
            beat_cnt_q <= '0;
            pack_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            inst_cnt_q <= inst_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            pack_q     <= pack_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign Inst_Wr_En   = wr_en_q;
    assign Inst_Wr_Addr = wr_addr_q;
    assign Inst_Wr_Data = wr_data_q;
    assign Load_Busy    = (state_q != S_IDLE);
    assign Load_Done    = (state_q == S_DONE);
endmodule
